// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a single synchronous FIFO.
// A granted requester keeps the port for up to MAX_BURST accepted beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GID_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state, state_nxt;
    logic [GID_W-1:0]    last_id, last_nxt;
    logic [GID_W-1:0]    grant_nxt;
    logic [GID_W-1:0]    winner;
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
    logic                accept;
    logic                last_beat;
    logic [DATA_WIDTH-1:0] sel_data;

    // Search last_id+1 .. last_id+NUM_REQ; a single subtract wraps since the sum stays below 2*NUM_REQ.
    always_comb begin
        int unsigned idx;
        logic        found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            idx = {{(32-GID_W){1'b0}}, last_id} + k;
            if (idx >= NREQ_U) idx = idx - NREQ_U;
            if (!found && req[GID_W'(idx)]) begin
                winner = GID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (GID_W'(i) == grant_id) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            beat_cnt <= '0;
            last_id  <= GID_W'(NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
            last_id  <= last_nxt;
        end
    end

    assign last_beat = (beat_cnt == BEAT_W'(MAX_BURST - 1));

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        beat_nxt  = beat_cnt;
        last_nxt  = last_id;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    grant_nxt = winner;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (!req[grant_id] || (accept && last_beat)) begin
                    state_nxt = IDLE;
                    last_nxt  = grant_id;
                end else if (accept) begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == GRANT);
        accept        = busy && req[grant_id] && !fifo_full;
        fifo_wr       = accept;
        ack           = '0;
        ack[grant_id] = accept;
        fifo_wr_data  = busy ? sel_data : '0;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle expected values written out by hand.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   ack;
    logic            fifo_full;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req = '0;
        fifo_full = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req = '0;
        fifo_full = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", fifo_wr); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        checks++; if (fifo_wr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", fifo_wr_data); end
        req = 4'b1111;
        next_cycle();
        #2;
        checks++; if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            errors++; $display("FAIL reset_held busy=%b wr=%b want 0 0", busy, fifo_wr);
        end
        req = '0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_single;
        logic [9:0] rq_t, busy_t, wr_t;
        logic [1:0] g_exp;
        rq_t   = 10'b0011111111;
        busy_t = 10'b0111011110;
        wr_t   = 10'b0011011110;
        for (int c = 0; c < 10; c++) begin
            req = rq_t[c] ? 4'b0100 : 4'b0000;
            #2;
            g_exp = (c == 0) ? 2'd0 : 2'd2;
            checks++; if (busy !== busy_t[c]) begin errors++; $display("FAIL single_busy c=%0d got %b want %b", c, busy, busy_t[c]); end
            checks++; if (fifo_wr !== wr_t[c]) begin errors++; $display("FAIL single_wr c=%0d got %b want %b", c, fifo_wr, wr_t[c]); end
            checks++; if (ack !== (wr_t[c] ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_ack c=%0d got %b", c, ack); end
            checks++; if (grant_id !== g_exp) begin errors++; $display("FAIL single_grant c=%0d got %0d want %0d", c, grant_id, g_exp); end
            if (wr_t[c]) begin
                checks++; if (fifo_wr_data !== 32'hA5A5_0002) begin errors++; $display("FAIL single_data c=%0d got %h want a5a50002", c, fifo_wr_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin;
        logic       b_exp;
        logic [1:0] g_exp;
        logic [31:0] d_exp;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            req = (c <= 24) ? 4'b1111 : 4'b0000;
            #2;
            b_exp = (c != 0) && (((c - 1) % 5) != 4);
            g_exp = 2'(((c - 1) / 5) % 4);
            d_exp = 32'hA5A5_0000 + 32'(g_exp);
            checks++; if (busy !== b_exp) begin errors++; $display("FAIL rr_busy c=%0d got %b want %b", c, busy, b_exp); end
            checks++; if (fifo_wr !== b_exp) begin errors++; $display("FAIL rr_wr c=%0d got %b want %b", c, fifo_wr, b_exp); end
            if (b_exp) begin
                checks++; if (grant_id !== g_exp) begin errors++; $display("FAIL rr_grant c=%0d got %0d want %0d", c, grant_id, g_exp); end
                checks++; if (ack !== (4'b0001 << g_exp)) begin errors++; $display("FAIL rr_ack c=%0d got %b", c, ack); end
                checks++; if (fifo_wr_data !== d_exp) begin errors++; $display("FAIL rr_data c=%0d got %h want %h", c, fifo_wr_data, d_exp); end
            end else begin
                checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rr_idle_ack c=%0d got %b want 0000", c, ack); end
            end
            next_cycle();
        end
    endtask

    task automatic test_full_stall;
        logic b_exp, w_exp;
        int   wr_cnt, ack_cnt;
        wr_cnt = 0;
        ack_cnt = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req = (c <= 7) ? 4'b0010 : 4'b0000;
            fifo_full = (c >= 3 && c <= 5);
            #2;
            b_exp = (c >= 1 && c <= 7);
            w_exp = b_exp && !fifo_full;
            checks++; if (busy !== b_exp) begin errors++; $display("FAIL stall_busy c=%0d got %b want %b", c, busy, b_exp); end
            checks++; if (fifo_wr !== w_exp) begin errors++; $display("FAIL stall_wr c=%0d got %b want %b", c, fifo_wr, w_exp); end
            checks++; if (ack !== (w_exp ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL stall_ack c=%0d got %b", c, ack); end
            if (b_exp) begin
                checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL stall_grant c=%0d got %0d want 1", c, grant_id); end
            end
            if (fifo_wr === 1'b1) begin
                wr_cnt++;
                checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL stall_wr_while_full c=%0d", c); end
                checks++; if (fifo_wr_data !== 32'hA5A5_0001) begin errors++; $display("FAIL stall_data c=%0d got %h want a5a50001", c, fifo_wr_data); end
            end
            if (ack !== 4'b0000) ack_cnt++;
            next_cycle();
        end
        fifo_full = 1'b0;
        checks++; if (wr_cnt !== 4) begin errors++; $display("FAIL stall_total_writes got %0d want 4", wr_cnt); end
        checks++; if (ack_cnt !== 4) begin errors++; $display("FAIL stall_total_acks got %0d want 4", ack_cnt); end
    endtask

    task automatic test_drop_release;
        logic [9:0] busy_t, wr_t;
        logic [3:0] rq;
        logic [1:0] g_exp;
        busy_t = 10'b0111101110;
        wr_t   = 10'b0111100110;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c <= 1)      rq = 4'b1000;
            else if (c == 2) rq = 4'b1001;
            else if (c <= 8) rq = 4'b0001;
            else             rq = 4'b0000;
            req = rq;
            #2;
            g_exp = (c <= 3) ? 2'd3 : 2'd0;
            checks++; if (busy !== busy_t[c]) begin errors++; $display("FAIL drop_busy c=%0d got %b want %b", c, busy, busy_t[c]); end
            checks++; if (fifo_wr !== wr_t[c]) begin errors++; $display("FAIL drop_wr c=%0d got %b want %b", c, fifo_wr, wr_t[c]); end
            if (busy_t[c] && c != 0) begin
                checks++; if (grant_id !== g_exp) begin errors++; $display("FAIL drop_grant c=%0d got %0d want %0d", c, grant_id, g_exp); end
            end
            if (wr_t[c]) begin
                checks++; if (fifo_wr_data !== (32'hA5A5_0000 + 32'(g_exp))) begin errors++; $display("FAIL drop_data c=%0d got %h", c, fifo_wr_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midburst;
        do_reset();
        req = 4'b0100;
        next_cycle();
        #2;
        checks++; if (busy !== 1'b1 || grant_id !== 2'd2 || fifo_wr !== 1'b1) begin
            errors++; $display("FAIL mid_beat0 busy=%b grant=%0d wr=%b want 1 2 1", busy, grant_id, fifo_wr);
        end
        next_cycle();
        #2;
        checks++; if (fifo_wr !== 1'b1 || ack !== 4'b0100) begin
            errors++; $display("FAIL mid_beat1 wr=%b ack=%b want 1 0100", fifo_wr, ack);
        end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL mid_wr got %b want 0", fifo_wr); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL mid_ack got %b want 0000", ack); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant got %0d want 0", grant_id); end
        req = 4'b0110;
        next_cycle();
        #2;
        checks++; if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            errors++; $display("FAIL mid_held busy=%b wr=%b want 0 0", busy, fifo_wr);
        end
        next_cycle();
        reset = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_arb busy=%b want 0", busy); end
        next_cycle();
        #2;
        checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin
            errors++; $display("FAIL mid_winner busy=%b grant=%0d want 1 1", busy, grant_id);
        end
        checks++; if (fifo_wr !== 1'b1 || fifo_wr_data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL mid_winner_data wr=%b data=%h want 1 a5a50001", fifo_wr, fifo_wr_data);
        end
        req = '0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drop_release();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one synchronous FIFO among NUM_REQ producers.
- Round-robin arbitration with burst locking: a winning requester keeps the port for up to MAX_BURST accepted beats, then the grant rotates.
- Sits directly in front of the FIFO. fifo_wr/fifo_wr_data drive the FIFO write inputs; fifo_full comes back from the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (>= 2).
- DATA_WIDTH, 32, FIFO word width.
- MAX_BURST, 4, maximum beats per grant (>= 1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  req[i]=1: requester i has a word on its data slice.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data on bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  ack[i]=1: requester i word accepted this cycle (combinational, one-hot or zero).
- fifo_full  in  1  FIFO full flag.
- fifo_wr  out  1  FIFO write strobe (combinational).
- fifo_wr_data  out  DATA_WIDTH  selected requester data (combinational mux by grant_id).
- grant_id  out  $clog2(NUM_REQ)  current owner index, registered.
- busy  out  1  1 while in GRANT state.

Behaviour:
- Interface: reset is reset, asynchronous, active-high; clock is clk.
- Reset values:
  - state=IDLE, grant_id=0, beat_cnt=0, last_id=NUM_REQ-1 (requester 0 has top priority first).
  - busy=0, fifo_wr=0, ack=0.
  - Async assert forces all of this immediately, including mid-burst; no write occurs while reset is high.
- States:
  - IDLE: if any req bit is set, winner = first set bit searching last_id+1, last_id+2, ... with wrap modulo NUM_REQ. Next edge: grant_id<=winner, beat_cnt<=0, state<=GRANT. With no req, stay in IDLE.
  - GRANT: accept = req[grant_id] & !fifo_full. Then fifo_wr=accept, ack[grant_id]=accept, all other ack bits 0.
- GRANT transitions, evaluated at the edge:
  - req[grant_id]=0: release. State<=IDLE, last_id<=grant_id, no write this cycle.
  - accept & beat_cnt==MAX_BURST-1: last beat is written, then release as above.
  - accept otherwise: beat_cnt<=beat_cnt+1.
  - fifo_full with req held: stall. No write, beat_cnt and grant unchanged, no timeout.
- Latency and throughput:
  - req rising with the FIFO not full: first write 1 cycle later, since IDLE costs exactly one arbitration cycle.
  - One IDLE bubble after every release, so peak throughput is MAX_BURST/(MAX_BURST+1) words per cycle.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits. The round-robin search is combinational over NUM_REQ and must be correct for non-power-of-2 NUM_REQ.
- Data rules:
  - fifo_wr_data = req_data slice of grant_id whenever busy; don't-care, driven 0, in IDLE.
  - Requesters must hold data stable while req=1 and ack=0.
- Fairness: a continuously requesting agent waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles plus full-stall cycles.
- fifo_wr is never asserted while fifo_full=1.

Test Plan:
- Only req[2] held, 6 words, MAX_BURST=4, full=0 -> grant_id=2 from cycle 1; fifo_wr high cycles 1-4; IDLE cycle 5; re-grant to 2; fifo_wr cycles 6-7; req drops -> IDLE.
- req=4'b1111 held continuously -> bursts of exactly 4 writes in grant order 0,1,2,3,0; one IDLE cycle between bursts; fifo_wr_data equals each owner's slice.
- Requester 1 granted; fifo_full=1 for 3 cycles after beat 2 -> fifo_wr=0 and ack=0 for those cycles; grant_id stays 1; exactly 4 total writes, then release.
- Requester 3 drops req after 2 beats, req[0] pending -> release without a write on the drop cycle; next grant goes to 0 (wrap from last_id=3); beat_cnt restarts at 0.
- Reset asserted mid-burst (owner 2, beat 1) -> busy, fifo_wr, ack drop to 0 in the same cycle; after deassert with req=4'b0110, requester 1 wins.
- Each req_data slice loaded with distinct values, e.g. 32'hA5A5_0000+i -> every FIFO write carries the owner's value; no write while full; total writes equal total ack pulses.
